// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one write port, write-to-read
// bypass, a per-register busy scoreboard and a one-register-per-cycle clear sweep.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                clr_req,
  output logic                clr_busy
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              idle;
  logic              wr_ok;
  logic              rsv_ok;

  assign idle     = (state_q == IDLE);
  assign clr_busy = rst_n && (state_q == CLEAR);

  // Register 0 is excluded from writes and reservations when hardwired to zero.
  assign wr_ok  = we && idle && (int'(waddr) < NREG) && !(ZERO_REG && (waddr == '0));
  assign rsv_ok = rsv_en && idle && (int'(rsv_addr) < NREG) && !(ZERO_REG && (rsv_addr == '0));

  always_comb begin : read_ports
    logic [AW-1:0] ra;
    // NOTE: every output is given a default before any branch so no latch is inferred.
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (rst_n && idle && rd_en[i] && (int'(ra) < NREG) && !(ZERO_REG && (ra == '0))) begin
        if (BYPASS && wr_ok && (waddr == ra)) begin
          rd_data[i*XLEN +: XLEN] = wdata;
          rd_busy[i]              = 1'b0;
        end else begin
          rd_data[i*XLEN +: XLEN] = regs_q[ra];
          rd_busy[i]              = busy_q[ra];
        end
      end
    end
  end

  always_comb begin : next_state
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (wr_ok) begin
          regs_d[waddr] = wdata;
          busy_d[waddr] = 1'b0;
        end
        // A same-cycle reservation is a newer producer, so it overrides the write's clear.
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the storage array is reset too, because the core relies on every register reading 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
      busy_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: the driver pushes expected read/clr results from an
// array-based reference model, a negedge monitor pops and compares them.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, nb_data;
  logic [NRD-1:0]      rd_busy, nb_busy;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                clr_req;
  logic                clr_busy, nb_clr_busy;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(clr_busy));

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(nb_data), .rd_busy(nb_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(nb_clr_busy));

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [1:0]  busy;
    logic        clrb;
    logic [63:0] nb_data;
    logic [1:0]  nb_busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   clr_cycles = 0;

  // Reference model: plain arrays plus "cycles of sweep left".
  logic [31:0] m_mem [NREG];
  bit          m_busy [NREG];
  int          sweep_left;

  task automatic check(input string name, input bit ok, input string detail);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    sweep_left = 0;
  endtask

  task automatic model_step();
    if (sweep_left > 0) begin
      m_mem[NREG - sweep_left]  = '0;
      m_busy[NREG - sweep_left] = 1'b0;
      sweep_left--;
    end else begin
      if (we && waddr != 0) begin
        m_mem[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      if (clr_req) sweep_left = NREG;
    end
  endtask

  function automatic logic [32:0] exp_read(input logic [4:0] a, input logic en, input bit byp);
    if (sweep_left > 0 || !en || a == 0) return '0;
    if (byp && we && waddr == a)         return {1'b0, wdata};
    return {m_busy[a], m_mem[a]};
  endfunction

  task automatic push(input string nm);
    exp_t        e;
    logic [32:0] r0, r1, n0, n1;
    r0 = exp_read(rd_addr[4:0], rd_en[0], 1'b1);
    r1 = exp_read(rd_addr[9:5], rd_en[1], 1'b1);
    n0 = exp_read(rd_addr[4:0], rd_en[0], 1'b0);
    n1 = exp_read(rd_addr[9:5], rd_en[1], 1'b0);
    e.name    = nm;
    e.data    = {r1[31:0], r0[31:0]};
    e.busy    = {r1[32], r0[32]};
    e.nb_data = {n1[31:0], n0[31:0]};
    e.nb_busy = {n1[32], n0[32]};
    e.clrb    = (sweep_left > 0);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, queue the expectation, let the edge happen, advance the model.
  task automatic cyc(input string nm, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                     input bit rs, input logic [4:0] ra, input bit cr,
                     input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    we = w; waddr = wa; wdata = wd; rsv_en = rs; rsv_addr = ra; clr_req = cr;
    rd_en = en; rd_addr = {a1, a0};
    push(nm);
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      bit   ok;
      e  = exp_q.pop_front();
      ok = (rd_data === e.data) && (rd_busy === e.busy) && (clr_busy === e.clrb) &&
           (nb_data === e.nb_data) && (nb_busy === e.nb_busy) && (nb_clr_busy === e.clrb);
      check(e.name, ok, $sformatf("got data=%h busy=%b clr=%b nb_data=%h nb_busy=%b, want data=%h busy=%b clr=%b nb_data=%h nb_busy=%b",
            rd_data, rd_busy, clr_busy, nb_data, nb_busy, e.data, e.busy, e.clrb, e.nb_data, e.nb_busy));
      if (clr_busy === 1'b1) clr_cycles++;
    end
  end

  initial begin
    // Reset with a live write/read pattern: outputs must still be zero.
    rst_n = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_0000; rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    model_reset();
    #1;
    check("reset_outputs", rd_data === '0 && rd_busy === '0 && clr_busy === 1'b0,
          $sformatf("got data=%h busy=%b clr=%b, want all 0", rd_data, rd_busy, clr_busy));
    we = 1'b0; rd_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write/read, zero register, bypass.
    cyc("t1_write_x5", 1, 5,  32'hDEADBEEF, 0, 0, 0, 2'b00, 0, 0);
    cyc("t1_read_x5",  0, 0,  0,            0, 0, 0, 2'b11, 5, 0);
    cyc("t2_write_x0", 1, 0,  32'h1234,     1, 0, 0, 2'b11, 0, 5);
    cyc("t2_read_x0",  0, 0,  0,            0, 0, 0, 2'b11, 0, 0);
    cyc("t3_prime_x7", 1, 7,  32'h1111_2222, 0, 0, 0, 2'b00, 0, 0);
    cyc("t3_bypass",   1, 7,  32'hA5A5A5A5, 0, 0, 0, 2'b11, 7, 5);
    cyc("t3_after",    0, 0,  0,            0, 0, 0, 2'b11, 7, 7);

    // Scoreboard busy tracking.
    cyc("t4_rsv_x9",   0, 0,  0,            1, 9, 0, 2'b01, 9, 0);
    cyc("t4_busy_x9",  0, 0,  0,            0, 0, 0, 2'b11, 9, 9);
    cyc("t4_rersv_x9", 0, 0,  0,            1, 9, 0, 2'b01, 9, 0);
    cyc("t4_wr_x9",    1, 9,  32'h42,       0, 0, 0, 2'b11, 9, 5);
    cyc("t4_free_x9",  0, 0,  0,            0, 0, 0, 2'b11, 9, 9);
    cyc("t4_rsv_wr",   1, 9,  32'h77,       1, 9, 0, 2'b10, 0, 9);
    cyc("t4_set_wins", 0, 0,  0,            0, 0, 0, 2'b11, 9, 9);

    // Full load, then clear sweep with a dropped write.
    for (int i = 1; i < NREG; i++)
      cyc("t5_load", 1, 5'(i), 32'h1000_0000 | i, 0, 0, 0, 2'b00, 0, 0);
    cyc("t5_load_chk", 0, 0, 0, 0, 0, 0, 2'b11, 31, 3);
    clr_cycles = 0;
    cyc("t5_clr_pulse", 0, 0, 0, 0, 0, 1, 2'b11, 3, 31);
    for (int k = 0; k < NREG + 1; k++)
      cyc("t5_sweep", (k == 5), 3, 32'hBAD0_0003, (k == 6), 4, 0, 2'b11, 3, 31);
    check("t5_clr_cycles", clr_cycles == NREG, $sformatf("got %0d cycles, want %0d", clr_cycles, NREG));
    for (int i = 0; i < NREG; i += 2)
      cyc("t5_all_zero", 0, 0, 0, 0, 0, 0, 2'b11, 5'(i), 5'(i + 1));

    // Reset in the middle of a sweep.
    cyc("t6_rsv_x20", 0, 0, 0, 1, 20, 0, 2'b00, 0, 0);
    cyc("t6_clr",     0, 0, 0, 0, 0, 1, 2'b11, 20, 0);
    for (int k = 0; k < 10; k++)
      cyc("t6_sweep", 0, 0, 0, 0, 0, 0, 2'b11, 20, 21);
    rst_n = 1'b0;
    #1;
    check("t6_reset_mid", rd_data === '0 && rd_busy === '0 && clr_busy === 1'b0,
          $sformatf("got data=%h busy=%b clr=%b, want all 0", rd_data, rd_busy, clr_busy));
    model_reset();
    rd_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("t6_after", 0, 0, 0, 0, 0, 0, 2'b11, 20, 9);
    cyc("t6_idle",  1, 20, 32'h5, 0, 0, 0, 2'b01, 20, 0);

    // Randomized traffic with a bias towards a few hot addresses.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, ra, a0, a1;
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) != 0) ? ra : 5'($urandom_range(0, 7));
      cyc("rand", bit'($urandom_range(0, 1)), wa, $urandom, bit'($urandom_range(0, 1)), ra,
          ($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), a0, a1);
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size() == 0, $sformatf("got %0d pending, want 0", exp_q.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
